// File: rtl/uart_mux_pkg.sv
// Shared types for the UART channel mux: switch FSM state encoding and the line idle level.
package uart_mux_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_PEND   = 2'd1,
    ST_GUARD  = 2'd2,
    ST_SWITCH = 2'd3
  } mux_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_mux_sync.sv
// Multi-flop synchronizer bank for the asynchronous pin_rx lines; every stage presets to the
// UART idle level so reset never looks like a start bit or a break.
module uart_mux_sync
  import uart_mux_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out
);

  logic [SYNC_STAGES-1:0] sync_reg [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg[gi] <= {SYNC_STAGES{UART_IDLE_LVL}};
        end else begin
          sync_reg[gi] <= {sync_reg[gi][SYNC_STAGES-2:0], async_in[gi]};
        end
      end
      assign sync_out[gi] = sync_reg[gi][SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/uart_channel_mux.sv
// Routes one UART core onto one of NUM_CH pin pairs, switching only when the line is quiescent.
// Optional per-channel break detection is built when UART_MUX_BREAK_DET_EN is defined.
module uart_channel_mux
  import uart_mux_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = $clog2(NUM_CH),
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 16,
  parameter int BREAK_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  sel_req,
  input  logic              sel_valid,
  output logic              sel_ready,
  output logic [SEL_W-1:0]  active_sel,
  output logic              switching,
  output logic              err_bad_sel,
  input  logic              core_tx,
  input  logic              core_tx_busy,
  output logic              core_rx,
  input  logic [NUM_CH-1:0] pin_rx,
  output logic [NUM_CH-1:0] pin_tx,
  output logic [NUM_CH-1:0] brk_det,
  input  logic [NUM_CH-1:0] brk_clr
);

  localparam int GCNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_CYCLES - 1);
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(NUM_CH);
  localparam int BRK_W = $clog2(BREAK_CYCLES + 1);
  localparam logic [BRK_W-1:0] BRK_MAX = BRK_W'(BREAK_CYCLES);

  logic [NUM_CH-1:0] rx_sync;
  mux_state_t        state_reg, state_next;
  logic [SEL_W-1:0]  target_reg, target_next;
  logic [SEL_W-1:0]  active_sel_reg, active_sel_next;
  logic [GCNT_W-1:0] guard_cnt_reg, guard_cnt_next;
  logic              err_bad_sel_reg, err_bad_sel_next;
  logic [NUM_CH-1:0] pin_tx_reg, pin_tx_next;
  logic              core_rx_reg;
  logic              post_switch_reg;
  logic              sel_rx;
  logic              line_idle;
  logic              req_bad;

  uart_mux_sync #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pin_rx),
    .sync_out (rx_sync)
  );

  // Compare-based select keeps the mux legal even when SEL_W is wider than needed.
  always_comb begin
    sel_rx = UART_IDLE_LVL;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_sel_reg == SEL_W'(i)) sel_rx = rx_sync[i];
    end
  end

  assign line_idle = (core_tx == UART_IDLE_LVL) && !core_tx_busy && (sel_rx == UART_IDLE_LVL);
  assign req_bad   = ({1'b0, sel_req} >= CH_LIMIT);

  always_comb begin
    state_next       = state_reg;
    target_next      = target_reg;
    active_sel_next  = active_sel_reg;
    guard_cnt_next   = guard_cnt_reg;
    err_bad_sel_next = 1'b0;
    case (state_reg)
      ST_ACTIVE: begin
        if (sel_valid) begin
          if (req_bad) begin
            err_bad_sel_next = 1'b1;
          end else if (sel_req != active_sel_reg) begin
            target_next = sel_req;
            state_next  = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        guard_cnt_next = '0;
        if (!core_tx_busy) state_next = ST_GUARD;
      end
      ST_GUARD: begin
        if (!line_idle) begin
          guard_cnt_next = '0;
          state_next     = ST_PEND;
        end else if (guard_cnt_reg == GUARD_LAST) begin
          guard_cnt_next = '0;
          state_next     = ST_SWITCH;
        end else begin
          guard_cnt_next = guard_cnt_reg + 1'b1;
        end
      end
      ST_SWITCH: begin
        active_sel_next = target_reg;
        state_next      = ST_ACTIVE;
      end
      default: state_next = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_ACTIVE;
      target_reg      <= '0;
      active_sel_reg  <= '0;
      guard_cnt_reg   <= '0;
      err_bad_sel_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      target_reg      <= target_next;
      active_sel_reg  <= active_sel_next;
      guard_cnt_reg   <= guard_cnt_next;
      err_bad_sel_reg <= err_bad_sel_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_tx
      assign pin_tx_next[gi] = (active_sel_reg == SEL_W'(gi)) ? core_tx : UART_IDLE_LVL;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pin_tx_reg      <= {NUM_CH{UART_IDLE_LVL}};
      core_rx_reg     <= UART_IDLE_LVL;
      post_switch_reg <= 1'b0;
    end else begin
      pin_tx_reg      <= pin_tx_next;
      core_rx_reg     <= sel_rx;
      post_switch_reg <= (state_reg == ST_SWITCH);
    end
  end

  // Hold RX at idle across the switch so the core never sees a glitch from either channel.
  assign core_rx     = core_rx_reg | (state_reg == ST_SWITCH) | post_switch_reg;
  assign pin_tx      = pin_tx_reg;
  assign active_sel  = active_sel_reg;
  assign sel_ready   = (state_reg == ST_ACTIVE);
  assign switching   = (state_reg != ST_ACTIVE);
  assign err_bad_sel = err_bad_sel_reg;

`ifdef UART_MUX_BREAK_DET_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_brk
      logic [BRK_W-1:0] brk_cnt_reg;
      logic             brk_flag_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          brk_cnt_reg  <= '0;
          brk_flag_reg <= 1'b0;
        end else begin
          if (brk_clr[gi] || rx_sync[gi]) brk_cnt_reg <= '0;
          else if (brk_cnt_reg != BRK_MAX) brk_cnt_reg <= brk_cnt_reg + 1'b1;
          // A saturated counter re-asserts the flag even against a simultaneous clear.
          if (brk_cnt_reg == BRK_MAX) brk_flag_reg <= 1'b1;
          else if (brk_clr[gi])       brk_flag_reg <= 1'b0;
        end
      end
      assign brk_det[gi] = brk_flag_reg;
    end
  endgenerate
`else
  logic unused_brk;
  assign unused_brk = ^{brk_clr, BRK_MAX};
  assign brk_det    = '0;
`endif

endmodule
